// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared definitions for the CPU front-end pipeline stages.
//   NOP_INST   : encoding placed in empty or masked instruction lanes
//   INST_BYTES : bytes per instruction word, used for next-PC arithmetic
//   fd_state_t : occupancy state of the fetch-to-decode stage
//   lane_lsb   : bit offset of a lane inside a packed instruction bundle
//   sat_inc32  : saturating 32-bit increment for event counters
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam int          INST_BYTES = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fd_state_t;

  // Lane 0 lives in the LSBs of a bundle; lane n starts at n*data_w.
  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One bundle storage register of the fetch-to-decode stage. Masked lanes are
// replaced by NOP as the bundle is loaded, so the stored copy is already in
// the form decode sees and the outputs need no further gating.
//   clk, rst          : clock, asynchronous active-low reset
//   clr               : synchronous clear to the all-zero (bubble) bundle
//   load              : capture the d_* bundle (clr wins over load)
//   d_inst/pc/next_pc/mask/exc : bundle to capture
//   q_inst/pc/next_pc/mask/exc : stored bundle
// -----------------------------------------------------------------------------
module pipe_slot
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic [LANES*DATA_W-1:0] d_inst,
  input  logic [ADDR_W-1:0]       d_pc,
  input  logic [ADDR_W-1:0]       d_next_pc,
  input  logic [LANES-1:0]        d_mask,
  input  logic                    d_exc,
  output logic [LANES*DATA_W-1:0] q_inst,
  output logic [ADDR_W-1:0]       q_pc,
  output logic [ADDR_W-1:0]       q_next_pc,
  output logic [LANES-1:0]        q_mask,
  output logic                    q_exc
);

  logic [LANES*DATA_W-1:0] inst_masked_s;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int LSB = lane_lsb(g, DATA_W);
    assign inst_masked_s[LSB +: DATA_W] = d_mask[g] ? d_inst[LSB +: DATA_W]
                                                    : DATA_W'(NOP_INST);
  end

  // Bundle storage: reset/clear to the bubble bundle, otherwise load or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_inst    <= {(LANES*DATA_W){1'b0}};
      q_pc      <= {ADDR_W{1'b0}};
      q_next_pc <= {ADDR_W{1'b0}};
      q_mask    <= {LANES{1'b0}};
      q_exc     <= 1'b0;
    end else if (clr) begin
      q_inst    <= {(LANES*DATA_W){1'b0}};
      q_pc      <= {ADDR_W{1'b0}};
      q_next_pc <= {ADDR_W{1'b0}};
      q_mask    <= {LANES{1'b0}};
      q_exc     <= 1'b0;
    end else if (load) begin
      q_inst    <= inst_masked_s;
      q_pc      <= d_pc;
      q_next_pc <= d_next_pc;
      q_mask    <= d_mask;
      q_exc     <= d_exc;
    end
  end

endmodule

// File: rtl/fd_pipe_skid.sv
// -----------------------------------------------------------------------------
// fd_pipe_skid
// Fetch-to-decode pipeline stage with valid/ready handshake and an optional
// second (skid) entry so fetch never loses a bundle under decode back-pressure.
// All decode-side outputs come straight from the main slot register.
//   clk, rst            : clock, asynchronous active-low reset
//   flush               : synchronous flush, empties the stage
//   in_valid/in_ready   : fetch-side handshake
//   in_inst/pc/mask/exc : fetch bundle (lane 0 in LSBs)
//   out_valid/out_ready : decode-side handshake
//   out_inst/pc/next_pc/mask/exc : bundle to decode; zero when empty
//   perf_stall/bubble/flush : event counters, present only when the
//                             FD_PERF_CNT_EN macro is defined
// Parameters: DATA_W, ADDR_W, LANES (1..4), SKID (1 = two entries with a
// registered in_ready, 0 = single entry with combinational in_ready).
// -----------------------------------------------------------------------------
module fd_pipe_skid
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LANES  = 1,
  parameter int SKID   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_inst,
  input  logic [ADDR_W-1:0]       in_pc,
  input  logic [LANES-1:0]        in_mask,
  input  logic                    in_exc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [ADDR_W-1:0]       out_next_pc,
  output logic [LANES-1:0]        out_mask,
  output logic                    out_exc
`ifdef FD_PERF_CNT_EN
  ,
  output logic [31:0]             perf_stall,
  output logic [31:0]             perf_bubble,
  output logic [31:0]             perf_flush
`endif
);

  fd_state_t state_r, state_nxt_s;
  logic      out_valid_r;
  logic      accept_s, consume_s;
  logic      main_load_s, main_clr_s, main_from_skid_s;
  logic      skid_load_s, skid_clr_s;

  logic [ADDR_W-1:0]       in_next_pc_s;
  logic [LANES*DATA_W-1:0] main_d_inst_s, skid_inst_s;
  logic [ADDR_W-1:0]       main_d_pc_s, skid_pc_s;
  logic [ADDR_W-1:0]       main_d_next_pc_s, skid_next_pc_s;
  logic [LANES-1:0]        main_d_mask_s, skid_mask_s;
  logic                    main_d_exc_s, skid_exc_s;

  assign accept_s     = in_valid && in_ready;
  assign consume_s    = out_valid_r && out_ready;
  assign out_valid    = out_valid_r;
  // Address arithmetic is modulo 2^ADDR_W; the carry out is simply dropped.
  assign in_next_pc_s = in_pc + ADDR_W'(INST_BYTES * LANES);

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s != EMPTY);
    end
  end

  // Next-state and slot control; flush dominates any accept/consume.
  always_comb begin
    state_nxt_s      = state_r;
    main_load_s      = 1'b0;
    main_clr_s       = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clr_s       = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
      main_clr_s  = 1'b1;
      skid_clr_s  = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ONE;
            main_load_s = 1'b1;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && consume_s) begin
            main_load_s = 1'b1;
          end else if (consume_s) begin
            state_nxt_s = EMPTY;
            main_clr_s  = 1'b1;
          end else if (accept_s && (SKID != 0)) begin
            // Decode stalled: park the new bundle behind the main one.
            state_nxt_s = FULL;
            skid_load_s = 1'b1;
          end else begin
            state_nxt_s = ONE;
          end
        end
        FULL: begin
          if (consume_s) begin
            state_nxt_s      = ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clr_s       = 1'b1;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          main_clr_s  = 1'b1;
          skid_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // Main slot source: the skid entry when draining FULL, else the fetch input.
  always_comb begin
    if (main_from_skid_s) begin
      main_d_inst_s    = skid_inst_s;
      main_d_pc_s      = skid_pc_s;
      main_d_next_pc_s = skid_next_pc_s;
      main_d_mask_s    = skid_mask_s;
      main_d_exc_s     = skid_exc_s;
    end else begin
      main_d_inst_s    = in_inst;
      main_d_pc_s      = in_pc;
      main_d_next_pc_s = in_next_pc_s;
      main_d_mask_s    = in_mask;
      main_d_exc_s     = in_exc;
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) u_main (
    .clk       (clk),
    .rst       (rst),
    .clr       (main_clr_s),
    .load      (main_load_s),
    .d_inst    (main_d_inst_s),
    .d_pc      (main_d_pc_s),
    .d_next_pc (main_d_next_pc_s),
    .d_mask    (main_d_mask_s),
    .d_exc     (main_d_exc_s),
    .q_inst    (out_inst),
    .q_pc      (out_pc),
    .q_next_pc (out_next_pc),
    .q_mask    (out_mask),
    .q_exc     (out_exc)
  );

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (skid_clr_s),
    .load      (skid_load_s),
    .d_inst    (in_inst),
    .d_pc      (in_pc),
    .d_next_pc (in_next_pc_s),
    .d_mask    (in_mask),
    .d_exc     (in_exc),
    .q_inst    (skid_inst_s),
    .q_pc      (skid_pc_s),
    .q_next_pc (skid_next_pc_s),
    .q_mask    (skid_mask_s),
    .q_exc     (skid_exc_s)
  );

  if (SKID != 0) begin : g_skid_ready
    logic in_ready_r;
    // Ready depends only on the next state, so out_ready never reaches
    // in_ready within the same cycle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        in_ready_r <= 1'b1;
      end else begin
        in_ready_r <= (state_nxt_s != FULL);
      end
    end
    assign in_ready = in_ready_r;
  end else begin : g_flow_ready
    assign in_ready = !out_valid_r || out_ready;
  end

`ifdef FD_PERF_CNT_EN
  // Saturating stall / bubble / flush event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall  <= 32'd0;
      perf_bubble <= 32'd0;
      perf_flush  <= 32'd0;
    end else begin
      if (out_valid_r && !out_ready) begin
        perf_stall <= sat_inc32(perf_stall);
      end
      if (!out_valid_r && !flush) begin
        perf_bubble <= sat_inc32(perf_bubble);
      end
      if (flush) begin
        perf_flush <= sat_inc32(perf_flush);
      end
    end
  end
`endif

endmodule

// File: doc/fd_pipe_skid.md
Name: fd_pipe_skid

Overview:
Parametrised fetch-to-decode pipeline stage and the next generation of the plain IF/ID latch.
- Replaces the stall/flush-only register with a valid/ready handshake and a 2-entry skid buffer, so fetch never loses an instruction when decode back-pressures.
- Carries LANES instructions per bundle, a lane mask and a fetch-exception tag.
- Sits between the fetch unit / I-cache response and the decoder.

Parameters:
DATA_W, 32, width of one instruction word
ADDR_W, 32, width of PC
LANES, 1, instructions per fetch bundle (1..4)
SKID, 1, 1 = 2-entry skid (in_ready registered); 0 = single entry, in_ready = !full || out_ready (combinational)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
flush  in  1  synchronous pipeline flush, highest priority after reset
in_valid  in  1  fetch bundle valid
in_ready  out  1  stage can accept bundle
in_inst  in  LANES*DATA_W  instruction words, lane 0 in LSBs
in_pc  in  ADDR_W  PC of lane 0
in_mask  in  LANES  per-lane valid
in_exc  in  1  fetch exception (misaligned PC / bus error)
out_valid  out  1  bundle valid to decode
out_ready  in  1  decode accepts (low = stall)
out_inst  out  LANES*DATA_W  instructions, masked lanes forced to NOP
out_pc  out  ADDR_W  PC of lane 0
out_next_pc  out  ADDR_W  out_pc + 4*LANES, modulo 2^ADDR_W
out_mask  out  LANES  lane valid
out_exc  out  1  exception tag

Behaviour:
- Reset (rst=0, async):
  - state EMPTY, out_valid=0, in_ready=1.
  - out_inst=0 (NOP), out_pc=0, out_next_pc=0, out_mask=0, out_exc=0.
- Accept: in_valid && in_ready. Consume: out_valid && out_ready.
- States:
  - EMPTY: main empty. Accept -> ONE.
  - ONE: main holds bundle.
    - accept && consume -> ONE (main <= input).
    - consume only -> EMPTY.
    - accept only -> FULL (input to skid; SKID=1 only).
  - FULL: main + skid both hold bundles; in_ready=0.
    - consume -> ONE, main <= skid.
- All outputs are driven from the main register; there is no combinational input->output path.
- Latency: 1 cycle from accept to out_valid when EMPTY.
- With SKID=0, FULL is unreachable. in_ready = !out_valid || out_ready.
- in_ready is registered when SKID=1: high in EMPTY/ONE, low in FULL.
- Flush:
  - Next state EMPTY and all outputs return to their reset values.
  - An input accepted in the same cycle is discarded.
  - Flush overrides accept/consume. in_ready=1 the cycle after a flush.
- Bubble: whenever main is empty, out_inst/out_pc/out_next_pc/out_mask/out_exc read 0.
- Masked lane: out_inst lane = 0 if out_mask bit = 0.
- in_exc=1: bundle passes normally with its mask, and out_exc marks it. The decoder squashes.
- out_valid never drops without a consume or flush, and data is stable while out_valid && !out_ready.
- No combinational path from out_ready to in_ready when SKID=1.
- Reset asserted mid-transfer clears immediately; no partial bundle survives.

Optional Feature:
FD_PERF_CNT_EN:
- Defined: adds outputs perf_stall[31:0], perf_bubble[31:0] and perf_flush[31:0], each saturating at 0xFFFFFFFF and cleared by rst.
  - perf_stall counts cycles with out_valid && !out_ready.
  - perf_bubble counts cycles with !out_valid && !flush.
  - perf_flush counts flush pulses.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package cpu_pipe_pkg holds:
  - NOP_INST = 32'h00000000
  - INST_BYTES = 4
  - the fd_state_t enum {EMPTY, ONE, FULL}
  - lane-select helper function.
- Sub-module pipe_slot: one bundle storage register with load and clear, instantiated twice (main and skid).

Test Plan:
- Reset then 1 bundle: in_pc=0x1000, in_inst=0x24020005, out_ready=1 -> next cycle out_valid=1, out_pc=0x1000, out_next_pc=0x1004; in_ready stays 1.
- Back-pressure: 3 back-to-back bundles pc 0x0/0x4/0x8 with out_ready=0 -> in_ready drops after the 2nd. Raising out_ready delivers 0x0, 0x4, 0x8 in order with no loss or duplication.
- Flush while FULL and accepting pc 0x20 -> next cycle out_valid=0, out_inst=0, in_ready=1; pc 0x20 is never output.
- LANES=2, in_mask=2'b01, in_inst={0xDEADBEEF,0x00000001}, pc=0xFFFFFFF8 -> out_inst upper lane=0, out_next_pc=0x00000000 (wrap).
- rst pulsed low mid-stream in FULL -> all outputs 0 asynchronously; the first bundle after release appears after 1 cycle.
- FD_PERF_CNT_EN: 5 stall cycles plus 1 flush -> perf_stall=5, perf_flush=1. Bubble counts match the idle cycles.
